// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: four-digit BCD stopwatch (SS.hh, 00.00..59.99).
// Drives the digit and decimal-point bus of the quad seven-segment display controller.
// Buttons arrive as single-cycle pulses. A pulse held for several cycles acts on every cycle.
// Optional lap/freeze display is enabled by defining LAP_STOPWATCH_EN.
// When the macro is undefined, lap_i is ignored and the live count is always shown.
module stopwatch_bcd_counter #(
   parameter int unsigned TICK_DIV = 1_000_000,
   parameter int unsigned PRESC_W  = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop_i,
   input  logic       clear_i,
   input  logic       lap_i,
   output logic [3:0] val3_o,
   output logic [3:0] val2_o,
   output logic [3:0] val1_o,
   output logic [3:0] val0_o,
   output logic       dot3_o,
   output logic       dot2_o,
   output logic       dot1_o,
   output logic       dot0_o,
   output logic       running_o,
   output logic       ovf_o
);

   localparam logic [PRESC_W-1:0] PrescMax = PRESC_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [3:0]         d3_q, d3_d;
   logic [3:0]         d2_q, d2_d;
   logic [3:0]         d1_q, d1_d;
   logic [3:0]         d0_q, d0_d;
   logic               ovf_q, ovf_d;
   logic               tick;

   assign tick = (state_q == StRun) && (presc_q == PrescMax);

   // Run-control FSM: state transitions and prescaler behaviour.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      unique case (state_q)
         StIdle: begin
            presc_d = '0;
            if (start_stop_i) state_d = StRun;
         end
         StRun: begin
            // Wrap on the tick cycle, otherwise keep counting the fraction.
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (start_stop_i) state_d = StPause;
         end
         StPause: begin
            // Hold the fraction so a resume finishes the interrupted hundredth.
            if (start_stop_i) state_d = StRun;
         end
         default: begin
            state_d = StIdle;
            presc_d = '0;
         end
      endcase
      // clear overrides start_stop in the same cycle.
      if (clear_i) begin
         state_d = StIdle;
         presc_d = '0;
      end
   end

   // BCD carry chain: one hundredth per tick, wrapping 59.99 -> 00.00 with sticky overflow.
   always_comb begin
      d3_d  = d3_q;
      d2_d  = d2_q;
      d1_d  = d1_q;
      d0_d  = d0_q;
      ovf_d = ovf_q;
      if (clear_i) begin
         d3_d  = 4'd0;
         d2_d  = 4'd0;
         d1_d  = 4'd0;
         d0_d  = 4'd0;
         ovf_d = 1'b0;
      end else if (tick) begin
         if (d0_q == 4'd9) begin
            d0_d = 4'd0;
            if (d1_q == 4'd9) begin
               d1_d = 4'd0;
               if (d2_q == 4'd9) begin
                  d2_d = 4'd0;
                  if (d3_q == 4'd5) begin
                     d3_d  = 4'd0;
                     ovf_d = 1'b1;
                  end else begin
                     d3_d = d3_q + 4'd1;
                  end
               end else begin
                  d2_d = d2_q + 4'd1;
               end
            end else begin
               d1_d = d1_q + 4'd1;
            end
         end else begin
            d0_d = d0_q + 4'd1;
         end
      end
   end

   // State, prescaler and count registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         presc_q <= '0;
         d3_q    <= 4'd0;
         d2_q    <= 4'd0;
         d1_q    <= 4'd0;
         d0_q    <= 4'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         d3_q    <= d3_d;
         d2_q    <= d2_d;
         d1_q    <= d1_d;
         d0_q    <= d0_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef LAP_STOPWATCH_EN
   logic       frozen_q, frozen_d;
   logic [3:0] lap3_q, lap3_d;
   logic [3:0] lap2_q, lap2_d;
   logic [3:0] lap1_q, lap1_d;
   logic [3:0] lap0_q, lap0_d;

   // Lap control: freeze captures the pre-edge live count; a second lap releases it.
   always_comb begin
      frozen_d = frozen_q;
      lap3_d   = lap3_q;
      lap2_d   = lap2_q;
      lap1_d   = lap1_q;
      lap0_d   = lap0_q;
      if (clear_i) begin
         frozen_d = 1'b0;
      end else if (lap_i) begin
         if (frozen_q) begin
            frozen_d = 1'b0;
         end else if (state_q == StRun) begin
            frozen_d = 1'b1;
            lap3_d   = d3_q;
            lap2_d   = d2_q;
            lap1_d   = d1_q;
            lap0_d   = d0_q;
         end
      end
   end

   // Lap register and freeze flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         frozen_q <= 1'b0;
         lap3_q   <= 4'd0;
         lap2_q   <= 4'd0;
         lap1_q   <= 4'd0;
         lap0_q   <= 4'd0;
      end else begin
         frozen_q <= frozen_d;
         lap3_q   <= lap3_d;
         lap2_q   <= lap2_d;
         lap1_q   <= lap1_d;
         lap0_q   <= lap0_d;
      end
   end

   // Display mux: the lap snapshot while frozen, otherwise the live count.
   always_comb begin
      val3_o = frozen_q ? lap3_q : d3_q;
      val2_o = frozen_q ? lap2_q : d2_q;
      val1_o = frozen_q ? lap1_q : d1_q;
      val0_o = frozen_q ? lap0_q : d0_q;
      dot0_o = frozen_q;
   end
`else
   logic unused_lap;
   assign unused_lap = lap_i;

   // Display shows the live count directly; no freeze indication.
   always_comb begin
      val3_o = d3_q;
      val2_o = d2_q;
      val1_o = d1_q;
      val0_o = d0_q;
      dot0_o = 1'b0;
   end
`endif

   assign dot3_o    = 1'b0;
   assign dot2_o    = 1'b1;
   assign dot1_o    = 1'b0;
   assign running_o = (state_q == StRun);
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter with TICK_DIV=4.
// Every fourth RUN clock is a tick, so the expected counts below are hand-computed.
module tb_stopwatch_bcd_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_stop_i = 1'b0;
   logic       clear_i = 1'b0;
   logic       lap_i = 1'b0;
   logic [3:0] val3_o, val2_o, val1_o, val0_o;
   logic       dot3_o, dot2_o, dot1_o, dot0_o;
   logic       running_o, ovf_o;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   stopwatch_bcd_counter #(
      .TICK_DIV(4),
      .PRESC_W (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_stop_i(start_stop_i),
      .clear_i     (clear_i),
      .lap_i       (lap_i),
      .val3_o      (val3_o),
      .val2_o      (val2_o),
      .val1_o      (val1_o),
      .val0_o      (val0_o),
      .dot3_o      (dot3_o),
      .dot2_o      (dot2_o),
      .dot1_o      (dot1_o),
      .dot0_o      (dot0_o),
      .running_o   (running_o),
      .ovf_o       (ovf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_ss();
      start_stop_i = 1'b1;
      clocks(1);
      start_stop_i = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      clocks(1);
      clear_i = 1'b0;
   endtask

   task automatic pulse_lap();
      lap_i = 1'b1;
      clocks(1);
      lap_i = 1'b0;
   endtask

   function automatic logic [31:0] disp();
      return {16'h0, val3_o, val2_o, val1_o, val0_o};
   endfunction

   function automatic logic [31:0] dots();
      return {28'h0, dot3_o, dot2_o, dot1_o, dot0_o};
   endfunction

   initial begin
      clocks(2);
      rst = 1'b0;
      check("reset_val", disp(), 32'h0000);
      check("reset_running", {31'h0, running_o}, 32'd0);
      check("reset_ovf", {31'h0, ovf_o}, 32'd0);
      check("reset_dots", dots(), 32'b0100);

      // Basic run: 40 clocks at 4 clocks/tick gives 00.10.
      pulse_ss();
      check("run_running", {31'h0, running_o}, 32'd1);
      clocks(40);
      check("run_40clk_val", disp(), 32'h0010);
      check("run_dot2", {31'h0, dot2_o}, 32'd1);

      // clear wins over start_stop in the same cycle.
      clear_i      = 1'b1;
      start_stop_i = 1'b1;
      clocks(1);
      clear_i      = 1'b0;
      start_stop_i = 1'b0;
      check("clr_prio_val", disp(), 32'h0000);
      check("clr_prio_running", {31'h0, running_o}, 32'd0);

      // Pause keeps the fractional tick; no increment while paused.
      pulse_ss();
      clocks(6);
      check("pre_pause_val", disp(), 32'h0001);
      pulse_ss();
      check("pause_running", {31'h0, running_o}, 32'd0);
      clocks(20);
      check("paused_val", disp(), 32'h0001);
      pulse_ss();
      check("resume_running", {31'h0, running_o}, 32'd1);
      clocks(2);
      check("resume_val", disp(), 32'h0002);
      pulse_clear();
      check("clear_val", disp(), 32'h0000);

      // Lap freeze at 00.05; live count reaches 00.15 after 40 more clocks.
      pulse_ss();
      clocks(20);
      check("lap_pre_val", disp(), 32'h0005);
      pulse_lap();
      clocks(40);
`ifdef LAP_STOPWATCH_EN
      check("lap_frozen_val", disp(), 32'h0005);
      check("lap_frozen_dot0", {31'h0, dot0_o}, 32'd1);
`else
      check("lap_ignored_val", disp(), 32'h0015);
      check("lap_ignored_dot0", {31'h0, dot0_o}, 32'd0);
`endif
      pulse_lap();
      check("lap_release_val", disp(), 32'h0015);
      check("lap_release_dot0", {31'h0, dot0_o}, 32'd0);
      // lap in PAUSE with no freeze active is ignored.
      pulse_ss();
      pulse_lap();
      check("lap_pause_dot0", {31'h0, dot0_o}, 32'd0);
      // clear drops an active freeze.
      pulse_ss();
      pulse_lap();
      pulse_clear();
      check("clear_unfreeze_dot0", {31'h0, dot0_o}, 32'd0);
      check("clear_unfreeze_val", disp(), 32'h0000);

      // Full-range run and overflow.
      pulse_ss();
      clocks(4 * 5999);
      check("full_5999_val", disp(), 32'h5999);
      check("full_5999_ovf", {31'h0, ovf_o}, 32'd0);
      clocks(4);
      check("wrap_val", disp(), 32'h0000);
      check("wrap_ovf", {31'h0, ovf_o}, 32'd1);
      check("wrap_running", {31'h0, running_o}, 32'd1);
      clocks(4);
      check("post_wrap_val", disp(), 32'h0001);
      check("ovf_sticky", {31'h0, ovf_o}, 32'd1);
      pulse_clear();
      check("ovf_clear", {31'h0, ovf_o}, 32'd0);
      check("ovf_clear_running", {31'h0, running_o}, 32'd0);

      // Synchronous reset mid-run at 12.34.
      pulse_ss();
      clocks(4 * 1234);
      check("mid_run_val", disp(), 32'h1234);
      rst = 1'b1;
      clocks(1);
      check("rst_val", disp(), 32'h0000);
      check("rst_running", {31'h0, running_o}, 32'd0);
      check("rst_ovf", {31'h0, ovf_o}, 32'd0);
      check("rst_dots", dots(), 32'b0100);
      rst = 1'b0;
      clocks(8);
      check("post_rst_idle", disp(), 32'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
